// File: rtl/axicb_slv_wch_order_if.sv
// axicb_slv_wch_order_if: AW grant sideband plus per-master and slave-side W channels
// for the write-data ordering stage.
interface axicb_slv_wch_order_if #(
    parameter int MST_NB     = 4,
    parameter int WCH_W      = 8,
    parameter int OSTDREQ_NB = 4
);
    logic [MST_NB-1:0]             aw_grant;
    logic                          aw_hs;
    logic                          aw_allow;
    logic [MST_NB-1:0]             i_wvalid;
    logic [MST_NB-1:0]             i_wready;
    logic [MST_NB-1:0]             i_wlast;
    logic [MST_NB*WCH_W-1:0]       i_wch;
    logic                          o_wvalid;
    logic                          o_wready;
    logic                          o_wlast;
    logic [WCH_W-1:0]              o_wch;
    logic [$clog2(OSTDREQ_NB):0]   ostd_cnt;
    modport slave (
        input  aw_grant, aw_hs, i_wvalid, i_wlast, i_wch, o_wready,
        output aw_allow, i_wready, o_wvalid, o_wlast, o_wch, ostd_cnt
    );
    modport master (
        output aw_grant, aw_hs, i_wvalid, i_wlast, i_wch, o_wready,
        input  aw_allow, i_wready, o_wvalid, o_wlast, o_wch, ostd_cnt
    );
endinterface

// File: rtl/axicb_slv_wch_order.sv
// axicb_slv_wch_order: queues AW grants and forwards W bursts only from the head
// master, in grant order, until its WLAST transfers.
module axicb_slv_wch_order #(
    parameter int MST_NB     = 4,
    parameter int WCH_W      = 8,
    parameter int OSTDREQ_NB = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    axicb_slv_wch_order_if.slave   bus
);
    localparam int PW = $clog2(OSTDREQ_NB);
    logic [MST_NB-1:0] r_fifo [OSTDREQ_NB];
    logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [PW:0]       r_cnt;
    logic              w_full, w_empty, w_push, w_pop;
    logic [MST_NB-1:0] w_head;
    logic [WCH_W-1:0]  w_wch;
    assign w_full  = r_cnt == (PW+1)'(OSTDREQ_NB);
    assign w_empty = r_cnt == '0;
    assign w_push  = bus.aw_hs & ~w_full;
    assign w_pop   = bus.o_wvalid & bus.o_wready & bus.o_wlast;
    assign w_head  = w_empty ? '0 : r_fifo[r_rd_ptr];
    always_comb begin
        w_wch = '0;
        for (int k = 0; k < MST_NB; k++)
            w_wch |= {WCH_W{w_head[k]}} & bus.i_wch[k*WCH_W +: WCH_W];
    end
    assign bus.aw_allow = ~w_full;
    assign bus.ostd_cnt = r_cnt;
    assign bus.o_wvalid = |(w_head & bus.i_wvalid);
    assign bus.o_wlast  = |(w_head & bus.i_wlast);
    assign bus.o_wch    = w_wch;
    assign bus.i_wready = w_head & {MST_NB{bus.o_wready}};
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end
    // storage needs no reset: entries are only read once counted in r_cnt
    always_ff @(posedge aclk) begin
        if (w_push) r_fifo[r_wr_ptr] <= bus.aw_grant;
    end
    a_no_push_full: assert property (@(posedge aclk) disable iff (!aresetn) bus.aw_hs |-> !w_full);
    a_grant_onehot: assert property (@(posedge aclk) disable iff (!aresetn) bus.aw_hs |-> $onehot(bus.aw_grant));
endmodule

// File: tb/tb_axicb_slv_wch_order.sv
// tb_axicb_slv_wch_order: scoreboard bench; each AW grant queues its expected beats,
// the slave-side monitor pops and compares every W transfer.
module tb_axicb_slv_wch_order;
    typedef struct packed {
        logic [1:0] k;
        logic       last;
        logic [7:0] d;
    } beat_t;
    logic aclk = 0;
    logic aresetn = 0;
    axicb_slv_wch_order_if #(.MST_NB(4), .WCH_W(8), .OSTDREQ_NB(4)) bus ();
    axicb_slv_wch_order #(.MST_NB(4), .WCH_W(8), .OSTDREQ_NB(4)) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus)
    );
    always #5 aclk = ~aclk;
    beat_t      exp_q [$];
    logic [8:0] mq [4][$];
    logic [1:0] rdy_mode = 2'd1;
    logic [3:0] fired = '0;
    int n_chk = 0, n_pass = 0, n_xfer = 0, n_pop = 0;
    logic       stall = 0;
    logic [9:0] stall_v = '0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
    endtask
    task automatic aw(input int k, input int len, input logic [7:0] base, input bit nb);
        int t = 0;
        while (!bus.aw_allow && t < 100) begin @(posedge aclk); #1; t++; end
        if (t == 100) chk("aw_allow_timeout", {31'd0, bus.aw_allow}, 1);
        bus.aw_hs = 1;
        bus.aw_grant = 4'b1 << k;
        for (int j = 0; j < len; j++) begin
            exp_q.push_back('{k: 2'(k), last: j == len-1, d: base + 8'(j)});
            mq[k].push_back({j == len-1, base + 8'(j)});
        end
        if (nb) begin #3; chk("no_bypass", {31'd0, bus.o_wvalid}, 0); end
        @(posedge aclk); #1;
        bus.aw_hs = 0;
        bus.aw_grant = '0;
    endtask
    task automatic wait_idle();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin @(negedge aclk); #1; t++; end
        if (t == 300) chk("drain_timeout", exp_q.size(), 0);
        @(posedge aclk); #1;
        chk("cnt_idle", 32'(bus.ostd_cnt), 0);
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_allow"}, {31'd0, bus.aw_allow}, 1);
        chk({tag, "_cnt"}, 32'(bus.ostd_cnt), 0);
        chk({tag, "_wvalid"}, {31'd0, bus.o_wvalid}, 0);
        chk({tag, "_wready"}, 32'(bus.i_wready), 0);
        chk({tag, "_wch"}, {22'd0, bus.o_wlast, bus.o_wch, 1'b0}, 0);
    endtask
    // master W drivers: each master shows the front of its queue, drops it after a transfer
    initial forever begin
        @(negedge aclk);
        fired = bus.i_wvalid & bus.i_wready;
        @(posedge aclk); #2;
        for (int k = 0; k < 4; k++) begin
            if (fired[k] && mq[k].size() > 0) mq[k].delete(0);
            bus.i_wvalid[k] = mq[k].size() > 0;
            {bus.i_wlast[k], bus.i_wch[k*8 +: 8]} = mq[k].size() > 0 ? mq[k][0] : 9'h0;
        end
        bus.o_wready = rdy_mode == 2'd2 ? ~bus.o_wready : rdy_mode[0];
    end
    initial forever begin
        @(negedge aclk);
        if (!aresetn) stall = 0;
        else begin
            if (stall) chk("stable", 32'({bus.o_wvalid, bus.o_wlast, bus.o_wch}), 32'(stall_v));
            stall = bus.o_wvalid && !bus.o_wready;
            stall_v = {bus.o_wvalid, bus.o_wlast, bus.o_wch};
            if (bus.o_wvalid && bus.o_wready) begin
                n_xfer++;
                if (bus.o_wlast) n_pop++;
                if (exp_q.size() == 0) chk("extra_beat", 0, 1);
                else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat", 32'({bus.o_wlast, bus.o_wch}), 32'({e.last, e.d}));
                    chk("wready", 32'(bus.i_wready), 32'(4'b1 << e.k));
                end
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int cyc, x0, p0;
        bus.aw_hs = 0; bus.aw_grant = '0; bus.i_wvalid = '0; bus.i_wlast = '0;
        bus.i_wch = '0; bus.o_wready = 1;
        for (int k = 0; k < 4; k++) mq[k].push_back({1'b1, 8'hE0 + 8'(k)});
        repeat (3) @(posedge aclk);
        #3;
        chk_reset("rst_hold");
        @(posedge aclk); #1;
        aresetn = 1;
        chk_reset("rst_rel");
        for (int k = 0; k < 4; k++) mq[k].delete();
        @(posedge aclk); #1;
        // reset asserted mid-burst flushes the queue
        aw(0, 6, 8'h40, 1);
        @(posedge aclk); #3;
        aresetn = 0;
        exp_q.delete();
        for (int k = 1; k < 4; k++) mq[k].push_back({1'b1, 8'hD0 + 8'(k)});
        #1;
        chk_reset("rst_async");
        repeat (2) @(posedge aclk);
        #3;
        aresetn = 1;
        chk_reset("rst_mid_rel");
        @(negedge aclk); #1;
        chk("rst_mid_wvalid", {31'd0, bus.o_wvalid}, 0);
        for (int k = 0; k < 4; k++) mq[k].delete();
        @(posedge aclk); #1;
        // single grant while master 0 waits with foreign data
        for (int j = 0; j < 4; j++) mq[0].push_back({j == 3, 8'hA0 + 8'(j)});
        aw(1, 4, 8'h10, 1);
        wait_idle();
        chk("m0_held", mq[0].size(), 4);
        mq[0].delete();
        @(posedge aclk); #1;
        // ordering 2,0,2 with no bubble between bursts
        rdy_mode = 0;
        aw(2, 3, 8'h20, 1);
        aw(0, 2, 8'h28, 0);
        aw(2, 3, 8'h2C, 0);
        rdy_mode = 1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin @(negedge aclk); #1; cyc++; end
        chk("no_bubble", cyc, 8);
        wait_idle();
        // full FIFO, allow returns only after the pop edge
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) aw(i, 1, 8'h50 + 8'(i), i == 0);
        chk("full_allow", {31'd0, bus.aw_allow}, 0);
        chk("full_cnt", 32'(bus.ostd_cnt), 4);
        rdy_mode = 1;
        @(negedge aclk); #1;
        chk("pop_cyc_allow", {31'd0, bus.aw_allow}, 0);
        @(posedge aclk); #1;
        rdy_mode = 0;
        #1;
        chk("after_pop_allow", {31'd0, bus.aw_allow}, 1);
        chk("after_pop_cnt", 32'(bus.ostd_cnt), 3);
        aw(0, 1, 8'h55, 0);
        chk("fifth_cnt", 32'(bus.ostd_cnt), 4);
        rdy_mode = 1;
        wait_idle();
        // simultaneous push/pop at cnt=2 across pointer wrap
        rdy_mode = 0;
        aw(0, 1, 8'h60, 1);
        aw(1, 1, 8'h61, 0);
        rdy_mode = 1;
        for (int i = 0; i < 10; i++) begin
            aw((i * 3) % 4, 1, 8'h70 + 8'(i), 0);
            chk("pp_cnt", 32'(bus.ostd_cnt), 2);
        end
        wait_idle();
        // backpressure on a 3-beat burst from master 3
        rdy_mode = 2;
        x0 = n_xfer;
        p0 = n_pop;
        aw(3, 3, 8'h30, 1);
        wait_idle();
        chk("bp_xfers", n_xfer - x0, 3);
        chk("bp_pops", n_pop - p0, 1);
        rdy_mode = 1;
        repeat (3) @(posedge aclk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
